// File: rtl/ser_pkg.sv
// rtl/ser_pkg.sv - shared types and defaults for the serial link (serializer/deserializer)
package ser_pkg;

  localparam int DATA_WIDTH_DEF = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SHIFT   = 2'd1,
    WAIT_RX = 2'd2
  } state_t;

endpackage

// File: rtl/serializer_tx.sv
// rtl/serializer_tx.sv - parallel-to-serial transmitter, MSB first, paced by receiver status
module serializer_tx
  import ser_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic                  clock_100KHZ,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  data_valid_in,
  output logic                  ack_out,
  input  logic                  status_in,
  output logic                  data_out,
  output logic                  write_out,
  output logic                  busy_out,
  output logic [7:0]            bytes_sent,
  output logic [1:0]            EA_ser
);

  localparam int CNT_W = $clog2(DATA_WIDTH);

  state_t                state;
  logic [DATA_WIDTH-1:0] shreg;
  logic [CNT_W-1:0]      bit_cnt;
  logic                  last_bit;

  assign last_bit = (bit_cnt == CNT_W'(DATA_WIDTH - 1));
  assign busy_out = (state != IDLE);
  assign EA_ser   = state;

  // State register: accept a word, shift it out, then wait for the receiver to drop status
  always_ff @(posedge clock_100KHZ or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE:    if (data_valid_in) state <= SHIFT;
        SHIFT:   if (status_in && last_bit) state <= WAIT_RX;
        WAIT_RX: if (!status_in) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Datapath: capture/ack, per-bit strobe while the receiver is ready, word counter
  always_ff @(posedge clock_100KHZ or posedge reset) begin
    if (reset) begin
      shreg      <= '0;
      bit_cnt    <= '0;
      bytes_sent <= 8'd0;
      data_out   <= 1'b0;
      write_out  <= 1'b0;
      ack_out    <= 1'b0;
    end else begin
      ack_out   <= 1'b0;
      write_out <= 1'b0;
      data_out  <= 1'b0;
      case (state)
        IDLE: begin
          if (data_valid_in) begin
            shreg   <= data_in;
            bit_cnt <= '0;
            ack_out <= 1'b1;
          end
        end
        SHIFT: begin
          // status low pauses the shift without losing or repeating a bit
          if (status_in) begin
            data_out  <= shreg[DATA_WIDTH-1];
            write_out <= 1'b1;
            shreg     <= {shreg[DATA_WIDTH-2:0], 1'b0};
            bit_cnt   <= bit_cnt + CNT_W'(1);
            if (last_bit) bytes_sent <= bytes_sent + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serializer_tx.sv
// tb/tb_serializer_tx.sv - directed self-checking bench for serializer_tx
`timescale 1ns/1ps
module tb_serializer_tx;

  logic       clock_100KHZ;
  logic       reset;
  logic [7:0] data_in;
  logic       data_valid_in;
  logic       ack_out;
  logic       status_in;
  logic       data_out;
  logic       write_out;
  logic       busy_out;
  logic [7:0] bytes_sent;
  logic [1:0] EA_ser;

  int checks   = 0;
  int failures = 0;
  int ack_cnt  = 0;
  int bad_ack  = 0;
  logic [1:0] prev_ea = 2'd0;

  serializer_tx #(.DATA_WIDTH(8)) dut (
    .clock_100KHZ  (clock_100KHZ),
    .reset         (reset),
    .data_in       (data_in),
    .data_valid_in (data_valid_in),
    .ack_out       (ack_out),
    .status_in     (status_in),
    .data_out      (data_out),
    .write_out     (write_out),
    .busy_out      (busy_out),
    .bytes_sent    (bytes_sent),
    .EA_ser        (EA_ser)
  );

  initial clock_100KHZ = 1'b0;
  always #5000 clock_100KHZ = ~clock_100KHZ;

  // ack pulses are counted away from the active edge; an ack is legal only right after an IDLE cycle
  always @(negedge clock_100KHZ) begin
    if (ack_out) begin
      ack_cnt++;
      if (prev_ea != 2'd0) bad_ack++;
    end
    prev_ea = EA_ser;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Offers one word (caller sits at a negedge), collects its 8 strobes, then drops status to release WAIT_RX
  task automatic run_word(input logic [7:0] w, input bit hold_valid, output logic [7:0] got);
    int n;
    bit seen;
    data_in = w;
    data_valid_in = 1'b1;
    status_in = 1'b1;
    seen = 0;
    for (int i = 0; i < 30 && !seen; i++) begin
      @(negedge clock_100KHZ);
      if (ack_out) seen = 1;
    end
    if (!seen) check("ack_timeout", 0, 1);
    if (!hold_valid) data_valid_in = 1'b0;
    got = 8'h00;
    n = 0;
    for (int i = 0; i < 30 && n < 8; i++) begin
      @(negedge clock_100KHZ);
      if (write_out) begin
        got = {got[6:0], data_out};
        n++;
      end
    end
    if (n != 8) check("strobe_timeout", n, 8);
    @(negedge clock_100KHZ);
    status_in = 1'b0;
    @(negedge clock_100KHZ);
    status_in = 1'b1;
  endtask

  logic [7:0] got;
  logic [7:0] exp_bits;
  int         a0;

  initial begin
    reset = 1'b1;
    data_in = 8'h00;
    data_valid_in = 1'b0;
    status_in = 1'b1;
    #1;
    check("rst_write", write_out, 0);
    check("rst_data", data_out, 0);
    check("rst_ack", ack_out, 0);
    check("rst_busy", busy_out, 0);
    check("rst_bytes", bytes_sent, 0);
    check("rst_state", EA_ser, 0);
    @(negedge clock_100KHZ);
    @(negedge clock_100KHZ);
    reset = 1'b0;

    // A5 with receiver always ready: ack, then 8 consecutive strobes
    data_in = 8'hA5;
    data_valid_in = 1'b1;
    @(negedge clock_100KHZ);
    check("a5_ack", ack_out, 1);
    check("a5_busy", busy_out, 1);
    check("a5_state_shift", EA_ser, 1);
    check("a5_no_strobe_yet", write_out, 0);
    data_valid_in = 1'b0;
    exp_bits = 8'hA5;
    for (int i = 0; i < 8; i++) begin
      @(negedge clock_100KHZ);
      check("a5_strobe", write_out, 1);
      check("a5_bit", data_out, exp_bits[7-i]);
      if (i == 0) check("a5_ack_once", ack_out, 0);
    end
    @(negedge clock_100KHZ);
    check("a5_wait_write", write_out, 0);
    check("a5_state_wait", EA_ser, 2);
    check("a5_bytes", bytes_sent, 1);
    @(negedge clock_100KHZ);
    check("a5_still_wait", EA_ser, 2);
    status_in = 1'b0;
    @(negedge clock_100KHZ);
    check("a5_idle", EA_ser, 0);
    check("a5_idle_busy", busy_out, 0);
    status_in = 1'b1;

    // F0 with a 4-cycle pause after the 3rd strobe
    data_in = 8'hF0;
    data_valid_in = 1'b1;
    @(negedge clock_100KHZ);
    check("f0_ack", ack_out, 1);
    data_valid_in = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock_100KHZ);
      check("f0_head_strobe", write_out, 1);
      check("f0_head_bit", data_out, 1);
    end
    status_in = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock_100KHZ);
      check("f0_pause_write", write_out, 0);
      check("f0_pause_state", EA_ser, 1);
    end
    status_in = 1'b1;
    exp_bits = 8'hF0;
    for (int i = 3; i < 8; i++) begin
      @(negedge clock_100KHZ);
      check("f0_tail_strobe", write_out, 1);
      check("f0_tail_bit", data_out, exp_bits[7-i]);
    end
    @(negedge clock_100KHZ);
    check("f0_bytes", bytes_sent, 2);
    status_in = 1'b0;
    @(negedge clock_100KHZ);
    status_in = 1'b1;

    // Loopback: receiver model reassembles 3C then C3
    a0 = ack_cnt;
    run_word(8'h3C, 0, got);
    check("loop_3c", got, 8'h3C);
    run_word(8'hC3, 0, got);
    check("loop_c3", got, 8'hC3);
    check("loop_acks", ack_cnt - a0, 2);
    check("loop_bytes", bytes_sent, 4);

    // Reset after the 5th bit of FF
    data_in = 8'hFF;
    data_valid_in = 1'b1;
    @(negedge clock_100KHZ);
    data_valid_in = 1'b0;
    for (int i = 0; i < 5; i++) @(negedge clock_100KHZ);
    check("ff_mid_strobe", write_out, 1);
    reset = 1'b1;
    #1;
    check("ff_rst_write", write_out, 0);
    check("ff_rst_data", data_out, 0);
    check("ff_rst_busy", busy_out, 0);
    check("ff_rst_state", EA_ser, 0);
    check("ff_rst_bytes", bytes_sent, 0);
    @(negedge clock_100KHZ);
    reset = 1'b0;
    run_word(8'h81, 0, got);
    check("post_rst_81", got, 8'h81);
    check("post_rst_bytes", bytes_sent, 1);

    // Valid held high for 256 words: one ack per word, counter wraps
    reset = 1'b1;
    @(negedge clock_100KHZ);
    reset = 1'b0;
    a0 = ack_cnt;
    for (int k = 0; k < 256; k++) begin
      run_word(k[7:0], 1, got);
      check("hold_word", got, k[7:0]);
      if (k == 254) check("hold_bytes_255", bytes_sent, 255);
    end
    data_valid_in = 1'b0;
    @(negedge clock_100KHZ);
    @(negedge clock_100KHZ);
    check("hold_acks", ack_cnt - a0, 256);
    check("hold_wrap", bytes_sent, 0);
    check("no_stray_ack", bad_ack, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
